// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: opcodes, instruction field positions and FSM state encoding for inst_seq
package inst_seq_pkg;
   localparam logic [2:0] OP_LOAD   = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b100;
   localparam logic [2:0] OP_MULADD = 3'b101;
   localparam logic [2:0] OP_MULSUB = 3'b110;
   localparam logic [2:0] OP_MAX    = 3'b111;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int REP_MSB = 4;
   localparam int REP_LSB = 0;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;
endpackage

// File: rtl/inst_seq.sv
// inst_seq: instruction buffer plus repeat-issue sequencer; INST_SEQ_LOOP_EN adds a loop_cnt program-repeat port
module inst_seq
   import inst_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_v,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          start,
   input  logic [AW:0]   prog_len,
   input  logic          hold,
`ifdef INST_SEQ_LOOP_EN
   input  logic [7:0]    loop_cnt,
`endif
   output logic          inst_v,
   output logic [2:0]    opcode,
   output logic          busy,
   output logic          done
);
   logic [7:0]    mem [DEPTH];
   logic [1:0]    state;
   logic [7:0]    inst;
   logic [AW-1:0] pc;
   logic [4:0]    rep_cnt;
   logic [AW:0]   len;
   logic          last_rep, last_pc, last_loop;
`ifdef INST_SEQ_LOOP_EN
   logic [7:0]    loop_n, loop_i;
   assign last_loop = loop_i == loop_n;
`else
   assign last_loop = 1'b1;
`endif
   assign last_rep = rep_cnt == inst[REP_MSB:REP_LSB];
   assign last_pc  = {1'b0, pc} == len - (AW+1)'(1);
   // decoder-facing outputs are pure functions of state so reset clears them on the next edge
   always_comb begin
      busy   = state == S_FETCH || state == S_ISSUE;
      done   = state == S_FIN;
      inst_v = state == S_ISSUE && !hold;
      opcode = inst_v ? inst[OP_MSB:OP_LSB] : OP_LOAD;
   end
   // buffer writes are locked out while a program runs; contents survive reset
   always_ff @(posedge clk)
      if (wr_v && !busy) mem[wr_addr] <= wr_data;
   // sequencer: fetch entry 0, then issue each entry rep+1 times with next-entry prefetch so there is no bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         rep_cnt <= '0;
`ifdef INST_SEQ_LOOP_EN
         loop_i  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (start) begin
               len   <= prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
               state <= prog_len == '0 ? S_FIN : S_FETCH;
`ifdef INST_SEQ_LOOP_EN
               loop_n <= loop_cnt;
               loop_i <= '0;
`endif
            end
            S_FETCH: begin
               inst    <= mem[0];
               rep_cnt <= '0;
               pc      <= '0;
               state   <= S_ISSUE;
            end
            S_ISSUE: if (!hold) begin
               if (!last_rep) rep_cnt <= rep_cnt + 5'd1;
               else if (!last_pc) begin
                  pc      <= pc + AW'(1);
                  inst    <= mem[pc + AW'(1)];
                  rep_cnt <= '0;
               end else if (!last_loop) begin
`ifdef INST_SEQ_LOOP_EN
                  loop_i  <= loop_i + 8'd1;
`endif
                  pc      <= '0;
                  inst    <= mem[0];
                  rep_cnt <= '0;
               end else state <= S_FIN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_seq.sv
// tb_inst_seq: directed and randomized checks of inst_seq against an expanded-opcode-queue model
module tb_inst_seq;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   logic clk = 0, rst = 1, wr_v = 0, start = 0, hold = 0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0] wr_data = '0, loop_cnt = '0;
   logic [AW:0] prog_len = '0;
   logic inst_v, busy, done;
   logic [2:0] opcode;
   logic [7:0] mdl [DEPTH];
   int passed = 0, total = 0, failed = 0;

   inst_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_v(wr_v), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .prog_len(prog_len), .hold(hold),
`ifdef INST_SEQ_LOOP_EN
      .loop_cnt(loop_cnt),
`endif
      .inst_v(inst_v), .opcode(opcode), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wr_v = 1; wr_addr = AW'(a); wr_data = d;
      tick();
      wr_v = 0;
      mdl[a] = d;
   endtask

   // hmode: 0 none, 1 random hold and stray starts, 2 hold in cycles 3-4
   task automatic run(input int len, input int loops, input int hmode, input int abort_at,
                      input bit junk, input int exp_done);
      logic [2:0] q[$];
      int n, cyc, reps;
      n = len > DEPTH ? DEPTH : len;
`ifdef INST_SEQ_LOOP_EN
      reps = loops + 1;
`else
      reps = 1;
`endif
      for (int l = 0; l < reps; l++)
         for (int i = 0; i < n; i++)
            for (int r = 0; r <= int'(mdl[i][4:0]); r++) q.push_back(mdl[i][7:5]);
      start = 1; prog_len = (AW+1)'(len); loop_cnt = 8'(loops);
      tick();
      start = 0; cyc = 1;
      if (n != 0) begin
         if (junk) begin wr_v = 1; wr_addr = '0; wr_data = 8'hFF; end
         @(negedge clk);
         chk("fetch_busy", busy, 1);
         chk("fetch_inst_v", inst_v, 0);
         tick();
         wr_v = 0; cyc = 2;
      end
      while (cyc < 3000) begin
         hold = hmode == 1 ? $urandom_range(0, 2) == 0 : hmode == 2 ? (cyc == 3 || cyc == 4) : 1'b0;
         start = hmode == 1 && q.size() > 0 ? 1'($urandom) : 1'b0;
         if (cyc == abort_at) rst = 1;
         @(negedge clk);
         if (q.size() == 0) begin
            chk("done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_inst_v", inst_v, 0);
            if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
            break;
         end
         chk("busy", busy, 1);
         chk("no_early_done", done, 0);
         if (hold) begin
            chk("hold_inst_v", inst_v, 0);
            chk("hold_opcode", opcode, 0);
         end else begin
            chk("inst_v", inst_v, 1);
            chk("opcode", opcode, q.pop_front());
         end
         if (cyc == abort_at) begin
            tick();
            rst = 0; hold = 0; start = 0;
            @(negedge clk);
            chk("abort_inst_v", inst_v, 0);
            chk("abort_busy", busy, 0);
            for (int k = 0; k < 4; k++) begin
               chk("abort_no_done", done, 0);
               tick();
            end
            return;
         end
         tick();
         cyc++;
      end
      if (cyc >= 3000) chk("timeout", 0, 1);
      tick();
      hold = 0; start = 0;
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_inst_v", inst_v, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      rst = 0;
      wr(0, 8'h80);
      wr(1, 8'hA2);
      run(2, 0, 0, -1, 0, 6);
      run(2, 0, 2, -1, 0, 8);
      run(0, 0, 0, -1, 0, 1);
      run(2, 0, 0, -1, 1, 6);
      run(2, 0, 0, -1, 0, 6);
      run(2, 0, 0, 3, 0, -1);
      run(2, 0, 0, -1, 0, 6);
`ifdef INST_SEQ_LOOP_EN
      run(2, 1, 0, -1, 0, 10);
`endif
      for (int i = 0; i < DEPTH; i++)
         wr(i, {3'($urandom), 5'($urandom_range(0, 3))});
      run(DEPTH, 0, 1, -1, 0, -1);
      run(DEPTH + 3, 0, 1, -1, 0, -1);
      for (int t = 0; t < 8; t++)
         run($urandom_range(1, DEPTH), $urandom_range(0, 2), 1, -1, 0, -1);
      run(1, 0, 0, -1, 0, 2 + int'(mdl[0][4:0]) + 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/inst_seq.md
INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 Parameter DEPTH, default 16: instruction-buffer entries; power of two, 2..64.
REQ-002 Parameter AW, default 4: buffer address width, equal to log2(DEPTH).
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port wr_v  input  1: buffer write strobe.
REQ-006 Port wr_addr  input  AW: buffer write address.
REQ-007 Port wr_data  input  8: instruction word; [7:5] opcode, [4:0] rep (issue rep+1 times).
REQ-008 Port start  input  1: one-cycle pulse that launches the program.
REQ-009 Port prog_len  input  AW+1: number of buffer entries to run, sampled on start.
REQ-010 Port hold  input  1: stall from downstream; when high, nothing is issued or advanced.
REQ-011 Port inst_v  output  1: instruction valid to the decoder.
REQ-012 Port opcode  output  3: opcode to the decoder (001 ADD, 010 SUB, 100 MUL, 101 MULADD, 110 MULSUB, 111 MAX, 000 LOAD).
REQ-013 Port busy  output  1: program in progress.
REQ-014 Port done  output  1: one-cycle pulse when the program completes.

Function
REQ-015 Buffer SHALL be a DEPTH x 8 array with combinational read and synchronous write; a write occurs when wr_v=1 and busy=0.
REQ-016 A write attempted while busy=1 SHALL be discarded.
REQ-017 FSM states SHALL be IDLE, FETCH, ISSUE and FIN.
- IDLE -> FETCH on start with prog_len != 0.
- IDLE -> FIN on start with prog_len == 0.
REQ-018 FETCH SHALL load the registered instruction from entry 0, clear rep_cnt, set pc=0 and go to ISSUE; this gives 2 cycles from start to the first inst_v.
REQ-019 In ISSUE with hold=0, inst_v SHALL be 1 and opcode SHALL equal the registered instruction's opcode.
REQ-020 In ISSUE with hold=1, inst_v SHALL be 0 and pc, rep_cnt and the registered instruction SHALL be unchanged.
REQ-021 In ISSUE with hold=0, the sequencer SHALL advance as follows.
- rep_cnt < rep: rep_cnt increments.
- rep_cnt == rep and pc < len-1: pc increments, entry pc+1 is loaded, rep_cnt clears, with no bubble.
- rep_cnt == rep and pc == len-1: go to FIN.
REQ-022 A prog_len value above DEPTH SHALL be clamped to DEPTH.
REQ-023 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 busy SHALL be 1 in FETCH and ISSUE and 0 in IDLE and FIN.
REQ-025 opcode SHALL be 000 whenever inst_v=0.
REQ-026 start SHALL be ignored when the FSM is not in IDLE.
REQ-027 Total issued instructions SHALL equal the sum of (rep+1) over entries 0..len-1, regardless of hold pattern.

Reset
REQ-028 rst=1 SHALL force IDLE and set inst_v=0, opcode=000, busy=0, done=0, pc=0 and rep_cnt=0 on the next edge.
REQ-029 A reset asserted mid-program SHALL abort it with no done pulse.
REQ-030 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro INST_SEQ_LOOP_EN SHALL select the program-loop feature.
- Defined: extra input loop_cnt (8 bits), sampled on start; the program runs loop_cnt+1 times back-to-back (pc wraps to 0 with no bubble) before FIN.
- Undefined: no loop_cnt port; the program runs exactly once.

Structure
REQ-032 Opcode localparams (ADD, SUB, MUL, MULADD, MULSUB, MAX, LOAD), instruction field positions and the FSM state encoding SHALL live in the shared parameters include.
REQ-033 The block SHALL be a single module; the buffer is inline, with no sub-module.

Verification
REQ-034 Load entry0=0x80 (MUL, rep 0) and entry1=0xA2 (MULADD, rep 2), prog_len=2, pulse start -> inst_v high from cycle 2 through cycle 5, opcode 100,101,101,101, then done at cycle 6.
REQ-035 Same program with hold=1 at cycles 3-4 -> inst_v low during the hold, 4 issues still occur, done at cycle 8.
REQ-036 prog_len=0 -> done pulses 1 cycle after start, inst_v never asserted.
REQ-037 wr_v during busy with wr_data=0xFF to entry 0, then rerun -> first opcode is still 100.
REQ-038 rst asserted at cycle 3 of a run -> inst_v=0 and busy=0 next cycle, no done pulse; a new start then runs normally.
REQ-039 With INST_SEQ_LOOP_EN, loop_cnt=1 and the program of REQ-034 -> 8 contiguous issues, then done.
